reg_file_2r1w: RTL and testbench



---
 rtl/reg_file_2r1w.sv | 41 ++++
 tb/tb_reg_file_2r1w.sv | 89 ++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 2-read/1-write register file with debug read port, reg 0 hardwired to zero; optional WB-to-ID bypass via REGFILE_BYPASS_EN
module reg_file_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] DebugAddr,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic [DATA_WIDTH-1:0] DebugData
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wr_hit;
    assign wr_hit = RegWrite && !Rst && (WriteReg != '0);
    // clear everything on reset (reset beats a same-edge write), else commit non-zero-address writes
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_hit) begin
            regs[WriteReg] <= WriteData;
        end
    end
    // reg 0 is masked on read so it is zero even before the first reset
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        ReadData1 = (ReadReg1 == '0) ? '0 : (wr_hit && ReadReg1 == WriteReg) ? WriteData : regs[ReadReg1];
        ReadData2 = (ReadReg2 == '0) ? '0 : (wr_hit && ReadReg2 == WriteReg) ? WriteData : regs[ReadReg2];
`else
        ReadData1 = (ReadReg1 == '0) ? '0 : regs[ReadReg1];
        ReadData2 = (ReadReg2 == '0) ? '0 : regs[ReadReg2];
`endif
        DebugData = (DebugAddr == '0) ? '0 : regs[DebugAddr];
    end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: scoreboard bench for reg_file_2r1w against a reference array model
module tb_reg_file_2r1w;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [4:0]  ReadReg1 = '0, ReadReg2 = '0, WriteReg = '0, DebugAddr = '0;
    logic [31:0] WriteData = '0;
    logic        RegWrite = 1'b0;
    logic [31:0] ReadData1, ReadData2, DebugData;
    logic [31:0] mdl [32];
    logic [31:0] sb [$];
    int          checks = 0;
    int          failures = 0;

    reg_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .Clk(Clk), .Rst(Rst), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .DebugAddr(DebugAddr), .ReadData1(ReadData1), .ReadData2(ReadData2),
        .DebugData(DebugData)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycle(input string tag, input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] da);
        logic hit;
        @(negedge Clk);
        Rst = rst; RegWrite = we; WriteReg = wa; WriteData = wd;
        ReadReg1 = r1; ReadReg2 = r2; DebugAddr = da;
        hit = BYP && we && !rst && wa != 5'd0;
        sb.push_back(r1 == 5'd0 ? 32'd0 : (hit && r1 == wa) ? wd : mdl[r1]);
        sb.push_back(r2 == 5'd0 ? 32'd0 : (hit && r2 == wa) ? wd : mdl[r2]);
        sb.push_back(da == 5'd0 ? 32'd0 : mdl[da]);
        #2;
        check({tag, ".rd1"}, ReadData1, sb.pop_front());
        check({tag, ".rd2"}, ReadData2, sb.pop_front());
        check({tag, ".dbg"}, DebugData, sb.pop_front());
        @(posedge Clk);
        if (rst) foreach (mdl[i]) mdl[i] = '0;
        else if (we && wa != 5'd0) mdl[wa] = wd;
    endtask

    initial begin
        foreach (mdl[i]) mdl[i] = '0;
        cycle("rst0", 1, 0, 0, 0, 0, 0, 0);
        cycle("rst_w5", 0, 1, 5, 32'hDEADBEEF, 5, 0, 5);
        cycle("rst_r5", 0, 0, 0, 0, 5, 5, 5);
        check("rst_pre_r5", ReadData1, 32'hDEADBEEF);
        cycle("rst_hit", 1, 0, 0, 0, 5, 5, 5);
        for (int a = 0; a < 32; a++) cycle("rst_sweep", 0, 0, 0, 0, a[4:0], 5'(31 - a), a[4:0]);
        cycle("r0_w", 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
        cycle("r0_r", 0, 0, 0, 0, 0, 0, 0);
        cycle("bw31", 0, 1, 31, 32'h12345678, 0, 0, 0);
        cycle("bw2", 0, 1, 2, 32'h0000000A, 31, 0, 31);
        cycle("br", 0, 0, 0, 0, 31, 2, 2);
        check("br_rd1", ReadData1, 32'h12345678);
        check("br_rd2", ReadData2, 32'h0000000A);
        cycle("rdw_w11", 0, 1, 8, 32'h11, 0, 0, 0);
        cycle("rdw", 0, 1, 8, 32'h22, 8, 8, 8);
        check("rdw_dbg_old", DebugData, 32'h11);
        cycle("rdw_post", 0, 0, 0, 0, 8, 8, 8);
        check("rdw_post_rd1", ReadData1, 32'h22);
        cycle("col_w33", 0, 1, 9, 32'h33, 0, 0, 0);
        cycle("col", 1, 1, 9, 32'h55, 9, 9, 9);
        check("col_nofwd", ReadData1, 32'h33);
        cycle("col_post", 0, 0, 0, 0, 9, 9, 9);
        check("col_post_rd1", ReadData1, 32'h0);
        for (int n = 0; n < 1000; n++)
            cycle("rand", ($urandom_range(0, 63) == 0), 1'($urandom), 5'($urandom), $urandom,
                  5'($urandom), 5'($urandom), 5'($urandom));
        @(negedge Clk);
        RegWrite = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
